// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front end: opcode encoding, data width
// and the sequencer state encoding.
package alu_pkg;

    localparam int ALU_W = 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        HOLD  = 2'b11
    } seq_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO. Pointers carry one extra wrap bit so that full
// and empty can be told apart when the index bits match.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Advance the read and write pointers; both may move in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Front end for the registered 4-bit ALU: buffers tagged commands, issues
// them one at a time, waits out the ALU latency and hands back the result.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1,
    parameter int TAG_W   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [ALU_W-1:0] cmd_a,
    input  logic [ALU_W-1:0] cmd_b,
    input  logic [1:0]       cmd_op,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [ALU_W-1:0] alu_a,
    output logic [ALU_W-1:0] alu_b,
    output logic [1:0]       alu_status,
    input  logic [ALU_W-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ALU_W-1:0] rsp_result,
    output logic [1:0]       rsp_op,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);

    localparam int FW    = 2*ALU_W + 2 + TAG_W;
    localparam int CNT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

    seq_state_t       state;
    logic [CNT_W-1:0] wait_cnt;
    logic [TAG_W-1:0] inflight_tag;
    logic             ready_en;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FW-1:0]    fifo_wdata;
    logic [FW-1:0]    fifo_rdata;

    logic [TAG_W-1:0] head_tag;
    logic [1:0]       head_op;
    logic [ALU_W-1:0] head_a;
    logic [ALU_W-1:0] head_b;

    // ready_en keeps cmd_ready low through reset and for the reset edge itself.
    assign cmd_ready  = ready_en && !fifo_full;
    assign fifo_push  = cmd_valid && cmd_ready;
    assign fifo_pop   = (state == IDLE) && !fifo_empty;
    assign fifo_wdata = {cmd_tag, cmd_op, cmd_a, cmd_b};
    assign {head_tag, head_op, head_a, head_b} = fifo_rdata;
    assign busy       = (state != IDLE) || !fifo_empty;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Issue/wait/respond sequencing with all ALU and response outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            inflight_tag <= '0;
            ready_en     <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_status   <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_op       <= '0;
            rsp_tag      <= '0;
        end else begin
            ready_en <= 1'b1;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        alu_a        <= head_a;
                        alu_b        <= head_b;
                        alu_status   <= head_op;
                        inflight_tag <= head_tag;
                        wait_cnt     <= CNT_W'(ALU_LAT);
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - CNT_W'(1);
                    if (wait_cnt == CNT_W'(1)) begin
                        rsp_result <= alu_result;
                        rsp_op     <= alu_status;
                        rsp_tag    <= inflight_tag;
                        rsp_valid  <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a registered ALU stand-in attached.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int DEPTH   = 4;
    localparam int ALU_LAT = 1;
    localparam int TAG_W   = 2;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [1:0]       op;
        logic [ALU_W-1:0] result;
    } rsp_t;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [ALU_W-1:0] cmd_a;
    logic [ALU_W-1:0] cmd_b;
    logic [1:0]       cmd_op;
    logic [TAG_W-1:0] cmd_tag;
    logic [ALU_W-1:0] alu_a;
    logic [ALU_W-1:0] alu_b;
    logic [1:0]       alu_status;
    logic [ALU_W-1:0] alu_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [ALU_W-1:0] rsp_result;
    logic [1:0]       rsp_op;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;

    rsp_t exp_q[$];
    rsp_t got_q[$];
    int   checks = 0;
    int   passed = 0;
    bit   rand_ready = 0;

    alu_op_sequencer #(
        .DEPTH   (DEPTH),
        .ALU_LAT (ALU_LAT),
        .TAG_W   (TAG_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .cmd_tag    (cmd_tag),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_status (alu_status),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_op     (rsp_op),
        .rsp_tag    (rsp_tag),
        .busy       (busy)
    );

    // 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ALU contract: 4-bit results, carry and borrow discarded.
    function automatic logic [ALU_W-1:0] alu_ref(input logic [ALU_W-1:0] a, input logic [ALU_W-1:0] b,
                                                 input logic [1:0] op);
        int r;
        case (op)
            OP_ADD:  r = (int'(a) + int'(b)) % 16;
            OP_SUB:  r = (int'(a) - int'(b) + 16) % 16;
            OP_AND:  r = int'(a & b);
            default: r = int'(a | b);
        endcase
        return r[ALU_W-1:0];
    endfunction

    // Registered ALU stand-in with a single edge of latency.
    always @(posedge clk) begin
        if (rst) alu_result <= '0;
        else     alu_result <= alu_ref(alu_a, alu_b, alu_status);
    end

    // Record every completed response handshake.
    always @(posedge clk) begin
        if (!rst && rsp_valid && rsp_ready) got_q.push_back({rsp_tag, rsp_op, rsp_result});
    end

    // Watchdog so the run always ends.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
        $fatal(1, "[TB] watchdog");
    end

    // Offer one command until accepted or max_cyc edges pass; called and returns at a negedge.
    task automatic send_cmd(input logic [ALU_W-1:0] a, input logic [ALU_W-1:0] b, input logic [1:0] op,
                            input logic [TAG_W-1:0] tag, input int max_cyc, output bit ok);
        bit acc;
        ok = 0;
        cmd_a = a;
        cmd_b = b;
        cmd_op = op;
        cmd_tag = tag;
        cmd_valid = 1'b1;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
            acc = cmd_ready;
            @(negedge clk);
            if (acc) begin
                ok = 1;
                exp_q.push_back({tag, op, alu_ref(a, b, op)});
            end
        end
        cmd_valid = 1'b0;
    endtask

    // Wait until every expected response has been received and the block is idle.
    task automatic wait_drain(input int base, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if ((got_q.size() - base) >= exp_q.size() && !busy) break;
            if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b1;
        cmd_a = 4'hA;
        cmd_b = 4'h5;
        cmd_op = OP_SUB;
        cmd_tag = 2'd3;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({cmd_ready, rsp_valid, busy, alu_a, alu_b, alu_status, rsp_result, rsp_op, rsp_tag} !== '0)
                $display("[TB] FAIL reset_outputs cycle %0d: got ready=%b valid=%b busy=%b alu=%h/%h/%h rsp=%h/%h/%h, required all 0",
                         i, cmd_ready, rsp_valid, busy, alu_a, alu_b, alu_status, rsp_result, rsp_op, rsp_tag);
            else passed++;
        end
        rst = 1'b0;
        cmd_valid = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0) $display("[TB] FAIL reset_ready_before_edge: got %b required 0", cmd_ready);
        else passed++;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0)
            $display("[TB] FAIL reset_release: got ready=%b busy=%b required ready=1 busy=0", cmd_ready, busy);
        else passed++;
    endtask

    task automatic test_four_ops();
        logic [ALU_W-1:0] k [4];
        int  base;
        int  lat;
        bit  ok;
        k = '{4'h7, 4'h1, 4'h0, 4'h7};
        exp_q.delete();
        base = got_q.size();
        rsp_ready = 1'b1;
        send_cmd(4'h4, 4'h3, OP_ADD, 2'd0, 4, ok);
        lat = -1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) begin
                checks++;
                if ({alu_a, alu_b, alu_status} !== {4'h4, 4'h3, OP_ADD})
                    $display("[TB] FAIL four_ops_issue: got alu=%h/%h/%h required 4/3/0", alu_a, alu_b, alu_status);
                else passed++;
            end
            if (rsp_valid) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat !== 3) $display("[TB] FAIL four_ops_latency: got %0d edges required 3", lat);
        else passed++;
        for (int i = 1; i < 4; i++) send_cmd(4'h4, 4'h3, 2'(i), 2'(i), 20, ok);
        wait_drain(base, 100);
        checks++;
        if (got_q.size() - base !== 4) $display("[TB] FAIL four_ops_count: got %0d required 4", got_q.size() - base);
        else passed++;
        for (int i = 0; i < 4 && base + i < got_q.size(); i++) begin
            checks++;
            if (got_q[base+i] !== exp_q[i] || got_q[base+i].result !== k[i] || got_q[base+i].tag !== 2'(i))
                $display("[TB] FAIL four_ops_rsp%0d: got %h required %h (result %h)", i, got_q[base+i], exp_q[i], k[i]);
            else passed++;
        end
    endtask

    task automatic test_wrap();
        logic [ALU_W-1:0] k [3];
        int base;
        bit ok;
        k = '{4'h8, 4'hD, 4'hF};
        exp_q.delete();
        base = got_q.size();
        rsp_ready = 1'b1;
        send_cmd(4'hF, 4'h9, OP_ADD, 2'd1, 20, ok);
        send_cmd(4'h2, 4'h5, OP_SUB, 2'd2, 20, ok);
        send_cmd(4'h8, 4'h7, OP_OR,  2'd3, 20, ok);
        wait_drain(base, 100);
        checks++;
        if (got_q.size() - base !== 3) $display("[TB] FAIL wrap_count: got %0d required 3", got_q.size() - base);
        else passed++;
        for (int i = 0; i < 3 && base + i < got_q.size(); i++) begin
            checks++;
            if (got_q[base+i] !== exp_q[i] || got_q[base+i].result !== k[i])
                $display("[TB] FAIL wrap_rsp%0d: got %h required %h (result %h)", i, got_q[base+i], exp_q[i], k[i]);
            else passed++;
        end
    endtask

    task automatic test_back_pressure();
        int   base;
        bit   ok;
        bit   seen;
        rsp_t head;
        exp_q.delete();
        base = got_q.size();
        rsp_ready = 1'b0;
        // With the consumer stalled, one command sits at the ALU and DEPTH wait in the FIFO.
        for (int i = 0; i < DEPTH + 1; i++) begin
            send_cmd(4'($urandom), 4'($urandom), 2'($urandom), 2'(i), 4, ok);
            checks++;
            if (ok !== 1'b1) $display("[TB] FAIL bp_accept%0d: got accepted=%b required 1", i, ok);
            else passed++;
        end
        checks++;
        if (cmd_ready !== 1'b0) $display("[TB] FAIL bp_full: got cmd_ready=%b required 0", cmd_ready);
        else passed++;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (rsp_valid) seen = 1;
            else @(negedge clk);
        end
        head = exp_q[0];
        cmd_a = 4'h1;
        cmd_b = 4'h1;
        cmd_op = OP_ADD;
        cmd_tag = 2'd1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({rsp_valid, rsp_tag, rsp_op, rsp_result} !== {1'b1, head} || cmd_ready !== 1'b0)
                $display("[TB] FAIL bp_hold%0d: got valid=%b rsp=%h ready=%b required valid=1 rsp=%h ready=0",
                         i, rsp_valid, {rsp_tag, rsp_op, rsp_result}, cmd_ready, head);
            else passed++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_drain(base, 100);
        checks++;
        if (got_q.size() - base !== DEPTH + 1)
            $display("[TB] FAIL bp_count: got %0d required %0d", got_q.size() - base, DEPTH + 1);
        else passed++;
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            checks++;
            if (got_q[base+i] !== exp_q[i]) $display("[TB] FAIL bp_rsp%0d: got %h required %h", i, got_q[base+i], exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int base;
        int n_ok;
        bit ok;
        exp_q.delete();
        base = got_q.size();
        rsp_ready = 1'b1;
        n_ok = 0;
        for (int i = 0; i < 12; i++) begin
            send_cmd(4'($urandom), 4'($urandom), 2'($urandom), 2'(i), 30, ok);
            if (ok) n_ok++;
        end
        checks++;
        if (n_ok !== 12) $display("[TB] FAIL b2b_accept: got %0d accepted required 12", n_ok);
        else passed++;
        wait_drain(base, 200);
        checks++;
        if (got_q.size() - base !== exp_q.size())
            $display("[TB] FAIL b2b_count: got %0d required %0d", got_q.size() - base, exp_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            checks++;
            if (got_q[base+i] !== exp_q[i]) $display("[TB] FAIL b2b_rsp%0d: got %h required %h", i, got_q[base+i], exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_random();
        int base;
        bit ok;
        exp_q.delete();
        base = got_q.size();
        rand_ready = 1;
        for (int i = 0; i < 16; i++) begin
            send_cmd(4'($urandom), 4'($urandom), 2'($urandom), 2'(i), 60, ok);
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                rsp_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
        end
        wait_drain(base, 400);
        rand_ready = 0;
        rsp_ready = 1'b1;
        checks++;
        if (got_q.size() - base !== exp_q.size() || exp_q.size() !== 16)
            $display("[TB] FAIL rand_count: got %0d responses for %0d accepted, required 16", got_q.size() - base, exp_q.size());
        else passed++;
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            checks++;
            if (got_q[base+i] !== exp_q[i]) $display("[TB] FAIL rand_rsp%0d: got %h required %h", i, got_q[base+i], exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_mid_reset();
        int base;
        bit ok;
        bit stale;
        exp_q.delete();
        rsp_ready = 1'b1;
        // First command is waiting on the ALU after the third accept, two more are queued.
        send_cmd(4'h3, 4'h4, OP_ADD, 2'd0, 4, ok);
        send_cmd(4'h5, 4'h1, OP_SUB, 2'd1, 4, ok);
        send_cmd(4'h6, 4'h3, OP_AND, 2'd2, 4, ok);
        base = got_q.size();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0)
            $display("[TB] FAIL midrst_state: got busy=%b rsp_valid=%b required 0/0", busy, rsp_valid);
        else passed++;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) stale = 1;
        end
        checks++;
        if (stale || got_q.size() != base)
            $display("[TB] FAIL midrst_stale: got %0d responses after reset (activity=%b) required 0", got_q.size() - base, stale);
        else passed++;
        exp_q.delete();
        send_cmd(4'h9, 4'hC, OP_OR, 2'd3, 4, ok);
        wait_drain(base, 50);
        checks++;
        if (got_q.size() - base !== 1 || (got_q.size() > base && got_q[base] !== exp_q[0]))
            $display("[TB] FAIL midrst_fresh: got %0d responses (first %h) required 1 of %h",
                     got_q.size() - base, (got_q.size() > base) ? got_q[base] : rsp_t'(0), exp_q[0]);
        else passed++;
    endtask

    // Run every scenario in order, then report.
    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_op = '0;
        cmd_tag = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_four_ops();
        test_wrap();
        test_back_pressure();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
